// File: rtl/nios_dbg_cmd_queue.sv
// Sysclk-side JTAG debug command path: strobe synchronisers, arming and a small command FIFO.
// Optional saturating drop counter on ovf_count when NIOS_DBG_CMD_OVFCNT_EN is defined.
module nios_dbg_cmd_queue #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_e1dr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DR_W-1:0]               sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [(2**IR_W)-1:0]          cmd_onehot,
    output logic [DR_W-1:0]               cmd_jdo,
    output logic                          uir_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic [CNT_W-1:0]              ovf_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IR_W + DR_W;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] e1dr_sync, uir_sync, fill;
    logic                   e1dr_hist, uir_hist;
    logic                   e1dr_armed, uir_armed;
    logic                   e1dr_rise;

    // The fill chain marks when the synchroniser outputs carry a real sample rather than
    // reset zeros, so a level held high across reset is never mistaken for a low.
    always_ff @(posedge clk) begin
        if (reset) begin
            e1dr_sync  <= '0;
            uir_sync   <= '0;
            fill       <= '0;
            e1dr_hist  <= 1'b0;
            uir_hist   <= 1'b0;
            e1dr_armed <= 1'b0;
            uir_armed  <= 1'b0;
        end else begin
            e1dr_sync  <= {e1dr_sync[SYNC_STAGES-2:0], vs_e1dr};
            uir_sync   <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
            e1dr_hist  <= e1dr_sync[SYNC_STAGES-1];
            uir_hist   <= uir_sync[SYNC_STAGES-1];
            if (fill[SYNC_STAGES-1] && !e1dr_sync[SYNC_STAGES-1]) e1dr_armed <= 1'b1;
            if (fill[SYNC_STAGES-1] && !uir_sync[SYNC_STAGES-1])  uir_armed  <= 1'b1;
        end
    end

    assign e1dr_rise = e1dr_armed & e1dr_sync[SYNC_STAGES-1] & ~e1dr_hist;
    assign uir_pulse = uir_armed & uir_sync[SYNC_STAGES-1] & ~uir_hist;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] count;
    logic             pop, drop, push;

    assign cmd_valid = (count != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign drop      = e1dr_rise & (count == LVL_FULL) & ~pop;
    assign push      = e1dr_rise & ~drop;

    // NOTE: storage is deliberately not reset; count gates visibility, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ir_in, sr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign {cmd_ir, cmd_jdo} = mem[rd_ptr];
    assign fifo_level        = count;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cmd_onehot = '0;
        if (cmd_valid) cmd_onehot[cmd_ir] = 1'b1;
    end

`ifdef NIOS_DBG_CMD_OVFCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset)                         ovf_count <= '0;
        else if (drop && ovf_clr)          ovf_count <= CNT_ONE;
        else if (ovf_clr)                  ovf_count <= '0;
        else if (drop && ovf_count != '1)  ovf_count <= ovf_count + CNT_ONE;
    end
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_nios_dbg_cmd_queue.sv
// Directed, table-driven bench for nios_dbg_cmd_queue at default parameters.
module tb_nios_dbg_cmd_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_e1dr, vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_ir;
    logic [3:0]  cmd_onehot;
    logic [37:0] cmd_jdo;
    logic        uir_pulse;
    logic [2:0]  fifo_level;
    logic        ovf_clr, overflow;
    logic [7:0]  ovf_count;

    int passed = 0;
    int total  = 0;

    nios_dbg_cmd_queue dut (
        .clk(clk), .reset(reset), .vs_e1dr(vs_e1dr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_onehot(cmd_onehot), .cmd_jdo(cmd_jdo),
        .uir_pulse(uir_pulse), .fifo_level(fifo_level), .ovf_clr(ovf_clr),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one edge and settle, so sampling is away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int idle);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < idle; i++) tick();
    endtask

    // One Exit1-DR scan: level high 4 cycles, low 3; optional pop on the push edge.
    task automatic capture(input logic [1:0] ir, input logic [37:0] d, input logic pop_at_push);
        ir_in = ir; sr = d; vs_e1dr = 1'b1;
        tick(); tick();
        if (pop_at_push) cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        vs_e1dr = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] d;
        logic        pop_at_push;
        logic [2:0]  exp_level;
        logic        exp_ovf;
    } cap_vec_t;

    cap_vec_t    vecs[7];
    logic [1:0]  drain_ir[4];
    logic [37:0] drain_d[4];
    int          pulses;
    logic [7:0]  exp_cnt;

    initial begin
        vecs[0] = '{2'd0, 38'h01_00000010, 1'b0, 3'd1, 1'b0};
        vecs[1] = '{2'd1, 38'h02_00000021, 1'b0, 3'd2, 1'b0};
        vecs[2] = '{2'd2, 38'h03_00000032, 1'b0, 3'd3, 1'b0};
        vecs[3] = '{2'd3, 38'h04_00000043, 1'b0, 3'd4, 1'b0};
        vecs[4] = '{2'd0, 38'h05_00000054, 1'b0, 3'd4, 1'b1};
        vecs[5] = '{2'd1, 38'h06_00000065, 1'b0, 3'd4, 1'b1};
        vecs[6] = '{2'd2, 38'h07_00000076, 1'b1, 3'd4, 1'b0};
        drain_ir = '{2'd1, 2'd2, 2'd3, 2'd2};
        drain_d  = '{38'h02_00000021, 38'h03_00000032, 38'h04_00000043, 38'h07_00000076};
`ifdef NIOS_DBG_CMD_OVFCNT_EN
        exp_cnt = 8'd2;
`else
        exp_cnt = 8'd0;
`endif

        reset = 1'b1; vs_e1dr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        do_reset(5);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_onehot", 64'(cmd_onehot), 64'd0);
        check("rst_uir", 64'(uir_pulse), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ovfcnt", 64'(ovf_count), 64'd0);

        // Single capture with latency check: valid appears on the third edge.
        ir_in = 2'b01; sr = 38'h2A_DEADBEEF; vs_e1dr = 1'b1;
        tick(); tick();
        check("lat_valid_2", 64'(cmd_valid), 64'd0);
        tick();
        check("lat_valid_3", 64'(cmd_valid), 64'd1);
        check("single_onehot", 64'(cmd_onehot), 64'b0010);
        check("single_ir", 64'(cmd_ir), 64'd1);
        check("single_jdo", 64'(cmd_jdo), 64'h2A_DEADBEEF);
        check("single_level", 64'(fifo_level), 64'd1);
        tick();
        vs_e1dr = 1'b0;
        tick(); tick(); tick();
        check("single_no_dup", 64'(fifo_level), 64'd1);
        pop_one();
        check("single_pop_level", 64'(fifo_level), 64'd0);
        check("single_pop_onehot", 64'(cmd_onehot), 64'd0);

        // Level held high across reset must not produce a command.
        vs_e1dr = 1'b1;
        do_reset(10);
        check("arm_held_level", 64'(fifo_level), 64'd0);
        vs_e1dr = 1'b0;
        tick(); tick(); tick(); tick();
        capture(2'd3, 38'h11_11111111, 1'b0);
        check("arm_one_push", 64'(fifo_level), 64'd1);
        check("arm_head_ir", 64'(cmd_ir), 64'd3);
        pop_one();

        // Overflow and full-with-pop table.
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                check("ovf_count", 64'(ovf_count), 64'(exp_cnt));
                ovf_clr = 1'b1;
                tick();
                ovf_clr = 1'b0;
                check("ovf_clr_flag", 64'(overflow), 64'd0);
                check("ovf_clr_count", 64'(ovf_count), 64'd0);
                check("full_head_ir0", 64'(cmd_ir), 64'd0);
            end
            capture(vecs[i].ir, vecs[i].d, vecs[i].pop_at_push);
            check($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_level));
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), 64'(cmd_valid), 64'd1);
            check($sformatf("drain%0d_ir", i), 64'(cmd_ir), 64'(drain_ir[i]));
            check($sformatf("drain%0d_onehot", i), 64'(cmd_onehot), 64'(4'b0001 << drain_ir[i]));
            check($sformatf("drain%0d_jdo", i), 64'(cmd_jdo), 64'(drain_d[i]));
            pop_one();
        end
        check("drain_empty", 64'(cmd_valid), 64'd0);

        // Update-IR pulses: one cycle each, queue untouched.
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            vs_uir = 1'b1;
            for (int t = 0; t < 3; t++) begin tick(); if (uir_pulse) pulses++; end
            vs_uir = 1'b0;
            for (int t = 0; t < 3; t++) begin tick(); if (uir_pulse) pulses++; end
        end
        check("uir_pulses", 64'(pulses), 64'd3);
        check("uir_level", 64'(fifo_level), 64'd0);

        // Reset mid-queue with overflow set.
        for (int i = 0; i < 5; i++) capture(2'(i), 38'(i + 100), 1'b0);
        pop_one();
        check("midq_level", 64'(fifo_level), 64'd3);
        check("midq_ovf", 64'(overflow), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midq_rst_valid", 64'(cmd_valid), 64'd0);
        check("midq_rst_level", 64'(fifo_level), 64'd0);
        check("midq_rst_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        capture(2'd2, 38'h3F_00C0FFEE, 1'b0);
        check("post_rst_level", 64'(fifo_level), 64'd1);
        check("post_rst_jdo", 64'(cmd_jdo), 64'h3F_00C0FFEE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
